// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Optional checksum stage is controlled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_len_lo = 3'd1,
    st_len_hi = 3'd2,
    st_data   = 3'd3,
    st_chk    = 3'd4,
    st_done   = 3'd5
  } state_t;

  // States in which the loader consumes a stream byte.
  function automatic logic is_accepting(input state_t s);
    return (s == st_len_lo) || (s == st_len_hi) || (s == st_data) || (s == st_chk);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host receiver / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);

  // Stream: a byte transfers on a rising edge where in_valid && in_ready;
  // once in_valid is high, in_byte stays stable until that transfer happens,
  // and in_ready never depends on in_valid.
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_byte_writer.sv
// Registered byte-write stage with address counter; drops bytes once
// MEM_BYTES payload bytes have been written and flags the overflow.
module imem_byte_writer #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        wr_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              ovf
);

  localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // Payload bytes written so far in this load; saturates at CAP.
  logic [ADDR_W:0] wr_cnt;
  logic            full;

  assign full = (wr_cnt == CAP);
  assign ovf  = accept && full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      mem_addr  <= BASE;
      wr_cnt    <= '0;
    end else begin
      mem_we <= accept && !full;
      if (accept && !full) begin
        mem_wdata <= wr_byte;
        wr_cnt    <= wr_cnt + (ADDR_W+1)'(1);
      end
      if (clear) begin
        mem_addr <= BASE;
        wr_cnt   <= '0;
      end else if (mem_we) begin
        // Address advances once the write it labelled has gone out.
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the instruction memory; holds the
// core in reset until loading completes. Define IMEM_LOADER_CHECKSUM_EN to
// add a trailing XOR checksum byte (CHK state).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold,
  output logic             err,
  output logic [LEN_W-1:0] byte_cnt,
  output state_t           state_dbg
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t DATA_EXIT = st_chk;
`else
  localparam state_t DATA_EXIT = st_done;
`endif

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             start_load;
  logic             data_acc;
  logic             len_zero;
  logic             last_byte;
  logic             wr_ovf;
  logic             chk_bad;

  assign bus.in_ready = is_accepting(state_q);
  assign accept       = bus.in_valid && bus.in_ready;
  assign data_acc     = accept && (state_q == st_data);
  assign len_zero     = ({bus.in_byte, len_q[7:0]} == '0);
  assign last_byte    = ((byte_cnt + LEN_W'(1)) == len_q);
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= st_idle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    case (state_q)
      st_idle, st_done: begin
        if (start) begin
          state_d    = st_len_lo;
          start_load = 1'b1;
        end
      end
      st_len_lo: if (accept) state_d = st_len_hi;
      st_len_hi: if (accept) state_d = len_zero ? st_done : st_data;
      st_data:   if (accept && last_byte) state_d = DATA_EXIT;
`ifdef IMEM_LOADER_CHECKSUM_EN
      st_chk:    if (accept) state_d = st_done;
`endif
      default:   state_d = st_idle;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          csum_q <= 8'h00;
    else if (start_load) csum_q <= 8'h00;
    else if (data_acc)   csum_q <= csum_q ^ bus.in_byte;
  end

  assign chk_bad = accept && (state_q == st_chk) && (bus.in_byte != csum_q);
`else
  assign chk_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else if (start_load) begin
      byte_cnt <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      if (accept && (state_q == st_len_lo)) len_q[7:0]  <= bus.in_byte;
      if (accept && (state_q == st_len_hi)) len_q[15:8] <= bus.in_byte;
      if (data_acc) byte_cnt <= byte_cnt + LEN_W'(1);
      if (wr_ovf || chk_bad) err <= 1'b1;
      // Status settles one cycle after DONE is entered; an error keeps the
      // core parked in reset.
      if (state_q == st_done) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        cpu_hold <= err;
      end
    end
  end

  imem_byte_writer #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_writer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load),
    .accept    (data_acc),
    .wr_byte   (bus.in_byte),
    .mem_we    (bus.mem_we),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .ovf       (wr_ovf)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; define IMEM_LOADER_CHECKSUM_EN to
// also exercise the checksum byte.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MEM_BYTES = 32;
  localparam int ADDR_W    = 5;
  localparam int BASE_ADDR = 0;
  localparam int EW        = 32 + ADDR_W + 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, cpu_hold, err;
  logic [LEN_W-1:0] byte_cnt;
  state_t           state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .err       (err),
    .byte_cnt  (byte_cnt),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pay_idx = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0] pay      [0:63];
  logic [7:0] mem_img  [0:MEM_BYTES-1];
  logic [7:0] gold_img [0:MEM_BYTES-1];

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, need finish before 400000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", name, got, need);
    end
  endtask

  // scoreboard: every write must match the expected queue head in cycle, address and data
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      if (bus.mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write_unexpected: got addr=%0d data=%02h cyc=%0d, need no write",
                   bus.mem_addr, bus.mem_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {32'(cyc), bus.mem_addr, bus.mem_wdata}) begin
            errors++;
            $display("FAIL mem_write: got cyc=%0d addr=%0d data=%02h, need cyc=%0d addr=%0d data=%02h",
                     cyc, bus.mem_addr, bus.mem_wdata, e[EW-1 -: 32], e[8 +: ADDR_W], e[7:0]);
          end
        end
        mem_img[bus.mem_addr] = bus.mem_wdata;
      end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        checks++;
        errors++;
        $display("FAIL mem_write_missing: got no write at cyc=%0d, need addr=%0d data=%02h",
                 cyc, exp_q[0][8 +: ADDR_W], exp_q[0][7:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_pay, input int max_gap);
    int gap;
    int budget;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    #1;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles, need 1");
    end else if (is_pay) begin
      // Model: the Nth payload byte goes to BASE+N one cycle later, only while N < MEM_BYTES.
      if (pay_idx < MEM_BYTES)
        exp_q.push_back({32'(cyc + 1), ADDR_W'((BASE_ADDR + pay_idx) % MEM_BYTES), b});
      pay_idx++;
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, need 1", done, budget);
    end
  endtask

  task automatic run_load(input int len, input int max_gap, input int start_at, input bit bad_chk);
    logic [7:0] x;
    logic       exp_err;
    int         mism;
    x       = 8'h00;
    pay_idx = 0;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err, 0);
    check("start_cnt_clr", byte_cnt, 0);
    check("start_hold", cpu_hold, 1);
    send_byte(len[7:0], 1'b0, max_gap);
    send_byte(len[15:8], 1'b0, max_gap);
    for (int i = 0; i < len; i++) begin
      if (i == start_at) begin
        bus.in_valid = 1'b0;
        pulse_start();
        check("start_ignored_busy", busy, 1);
        check("start_ignored_cnt", byte_cnt, i);
      end
      send_byte(pay[i], 1'b1, max_gap);
      x ^= pay[i];
    end
    if (CHK_ON && len != 0) send_byte(x ^ {7'd0, bad_chk}, 1'b0, max_gap);
    bus.in_valid = 1'b0;
    wait_done(20);
    exp_err = (len > MEM_BYTES) || (CHK_ON && bad_chk);
    check("final_busy", busy, 0);
    check("final_done", done, 1);
    check("final_err", err, exp_err);
    check("final_hold", cpu_hold, exp_err);
    check("final_cnt", byte_cnt, len);
    check("writes_drained", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < len && i < MEM_BYTES; i++)
      if (mem_img[(BASE_ADDR + i) % MEM_BYTES] !== pay[i]) mism++;
    check("mem_image", mism, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, BASE_ADDR);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_hold"}, cpu_hold, 1);
    check({tag, "_cnt"}, byte_cnt, 0);
    check({tag, "_state"}, state_dbg, st_idle);
  endtask

  initial begin
    int mism;
    int rlen;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    for (int i = 0; i < MEM_BYTES; i++) mem_img[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);

    // idle ignores stream bytes
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h5a;
    repeat (3) @(negedge clk);
    check("idle_ready", bus.in_ready, 0);
    check("idle_state", state_dbg, st_idle);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // full 32-byte image, no gaps
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    pay[0] = 8'h33; pay[1] = 8'h03; pay[2] = 8'h94; pay[3] = 8'h00;
    run_load(32, 0, -1, 1'b0);
    check("lit_cnt32", byte_cnt, 16'd32);
    check("lit_img0", mem_img[0], 8'h33);
    check("lit_img2", mem_img[2], 8'h94);
    check("lit_hold_released", cpu_hold, 0);
    for (int i = 0; i < MEM_BYTES; i++) gold_img[i] = mem_img[i];

    // zero length: no writes, done two cycles after the second length byte
    pulse_start();
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    bus.in_valid = 1'b0;
    check("zero_done_early", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_hold", cpu_hold, 0);
    check("zero_cnt", byte_cnt, 0);

    // overflow: 34 bytes into 32-byte memory
    pay[32] = 8'($urandom);
    pay[33] = 8'($urandom);
    run_load(34, 0, -1, 1'b0);
    check("lit_ovf_err", err, 1);
    check("lit_ovf_hold", cpu_hold, 1);
    check("lit_ovf_cnt", byte_cnt, 16'd34);

    // random gaps plus a start pulse while busy
    for (int i = 0; i < MEM_BYTES; i++) mem_img[i] = 8'h00;
    run_load(32, 3, 10, 1'b0);
    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem_img[i] !== gold_img[i]) mism++;
    check("gap_image_same", mism, 0);

    // reset after five payload bytes
    pulse_start();
    pay_idx = 0;
    send_byte(8'h10, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("abort");
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    run_load(4, 0, -1, 1'b0);
    check("lit_fresh0", mem_img[0], 8'hAA);
    check("lit_fresh3", mem_img[3], 8'hDD);
    check("lit_fresh_addr", bus.mem_addr, 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04;
    run_load(3, 0, -1, 1'b0);
    check("lit_chk_good", err, 0);
    run_load(3, 0, -1, 1'b1);
    check("lit_chk_bad", err, 1);
`endif

    // randomized loads
    for (int k = 0; k < 4; k++) begin
      rlen = int'($urandom_range(40, 1));
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_load(rlen, 2, -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
